// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the active-high glyph lookup.
// Bit indices use a _BIT suffix because SEG_A..SEG_F already name the hex glyphs.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int SEG_BIT_A = 6;
  localparam int SEG_BIT_B = 5;
  localparam int SEG_BIT_C = 4;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 2;
  localparam int SEG_BIT_F = 1;
  localparam int SEG_BIT_G = 0;

  // Returns the active-high pattern; unknown inputs fall to blank.
  function automatic logic [6:0] seg7_lookup(input logic [3:0] num, input logic hex_mode);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (num)
      4'd0:  pat = SEG_0;
      4'd1:  pat = SEG_1;
      4'd2:  pat = SEG_2;
      4'd3:  pat = SEG_3;
      4'd4:  pat = SEG_4;
      4'd5:  pat = SEG_5;
      4'd6:  pat = SEG_6;
      4'd7:  pat = SEG_7;
      4'd8:  pat = SEG_8;
      4'd9:  pat = SEG_9;
      4'd10: pat = hex_mode ? SEG_A : SEG_BLANK;
      4'd11: pat = hex_mode ? SEG_B : SEG_BLANK;
      4'd12: pat = hex_mode ? SEG_C : SEG_BLANK;
      4'd13: pat = hex_mode ? SEG_D : SEG_BLANK;
      4'd14: pat = hex_mode ? SEG_E : SEG_BLANK;
      4'd15: pat = hex_mode ? SEG_F : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational digit-to-segment lookup, active-high output.
module seg7_lut
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] num,
  output logic [6:0] pat
);

  always_comb begin
    pat = seg7_lookup(num, HEX_MODE);
  end

endmodule

// File: rtl/bcd_segment_decoder.sv
// BCD/hex to 7-segment decoder with polarity select and a registered output.
module bcd_segment_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  output logic [6:0] a_g
);

  localparam logic [6:0] BLANK_WORD = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [6:0] pat;
  logic [6:0] a_g_d;
  logic [6:0] a_g_q;

  seg7_lut #(.HEX_MODE(HEX_MODE)) u_lut (
    .num (num),
    .pat (pat)
  );

  // Inversion is applied after the lookup so blank follows polarity too.
  always_comb begin
    a_g_d = pat;
    if (ACTIVE_LOW) a_g_d = ~pat;
  end

  always_ff @(posedge clk) begin
    if (rst) a_g_q <= BLANK_WORD;
    else     a_g_q <= a_g_d;
  end

  assign a_g = a_g_q;

endmodule

// File: tb/tb_bcd_segment_decoder.sv
// Directed bench over three builds: default, HEX_MODE=1, and ACTIVE_LOW=1 with HEX_MODE=1.
module tb_bcd_segment_decoder;

  typedef struct {
    logic [6:0] d;
    logic [6:0] h;
    logic [6:0] i;
  } exp_t;

  localparam logic [6:0] PAT_DEC [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [6:0] PAT_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic       clk;
  logic       rst;
  logic [3:0] num;
  logic [6:0] a_def, a_hex, a_inv;

  int vectors;
  int miscompares;
  exp_t sb[$];

  bcd_segment_decoder u_def (.clk(clk), .rst(rst), .num(num), .a_g(a_def));
  bcd_segment_decoder #(.HEX_MODE(1'b1)) u_hex (.clk(clk), .rst(rst), .num(num), .a_g(a_hex));
  bcd_segment_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_inv (
    .clk(clk), .rst(rst), .num(num), .a_g(a_inv));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one vector at the falling edge, score it after the next rising edge.
  task automatic step(input string tag, input logic r, input logic [3:0] n);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r;
    num = n;
    if (r) e = '{7'h00, 7'h00, 7'h7F};
    else   e = '{PAT_DEC[n], PAT_HEX[n], ~PAT_HEX[n]};
    sb.push_back(e);
    vectors++;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, "/def"}, a_def, got.d);
    check({tag, "/hex"}, a_hex, got.h);
    check({tag, "/inv"}, a_inv, got.i);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    num = 4'd5;

    step("reset0", 1'b1, 4'd5);
    step("reset1", 1'b1, 4'd5);
    step("release", 1'b0, 4'd5);

    for (int k = 0; k < 10; k++) step($sformatf("dec%0d", k), 1'b0, 4'(k));
    for (int k = 10; k < 16; k++) step($sformatf("hex%0d", k), 1'b0, 4'(k));

    step("pol8", 1'b0, 4'd8);
    step("pol1", 1'b0, 4'd1);
    step("polrst", 1'b1, 4'd1);

    for (int k = 0; k < 40; k++) step($sformatf("cnt%0d", k), 1'b0, 4'((k + 7) % 16));

    step("mid_pre", 1'b0, 4'd2);
    step("mid_rst", 1'b1, 4'd3);
    step("mid_3", 1'b0, 4'd3);
    step("mid_4", 1'b0, 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
